add_serial_feeder: RTL and testbench
====================================

Name: add_serial_feeder

Overview:
- Operand sequencer that sits directly upstream of the 8-bit bit-serial adder.
- Buffers operand pairs from a valid/ready source and drives the adder's a/b/en inputs.
- Times the adder's fixed serial latency, captures its parallel out, and presents each sum on a valid/ready result port.
- Back-to-back throughput is one sum every ADD_LAT+3 cycles.

Parameters:
- W, 8, operand/result width; must match the adder.
- DEPTH, 2, input FIFO entries; power of two, ≥2.
- ADD_LAT, 8, cycles WAIT holds after the START edge before add_out is final (8 serial bit cycles).
- EN_ASSERT, 1'b0, level of add_en that the adder treats as asserted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO not full.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- add_a  out  W  to adder a.
- add_b  out  W  to adder b.
- add_en  out  1  to adder en.
- add_out  in  W  from adder out.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_sum  out  W  captured sum.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst low, async):
  - FIFO empty; in_ready=1.
  - add_a=add_b=0; add_en=~EN_ASSERT.
  - res_valid=0, res_sum=0; FSM=IDLE; wait counter=0.
  - Reset mid-operation abandons the operation; no partial result is emitted.
- FIFO:
  - Push when in_valid&&in_ready. in_ready=!full, registered from occupancy, so there is no push when full, even with a same-cycle pop.
  - Pop occurs on the cycle the FSM enters START. Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full: occupancy unchanged.
- FSM states: IDLE, START, WAIT, CAPT, REL.
- IDLE:
  - FIFO non-empty -> START; the head is popped into add_a/add_b at that edge.
  - Otherwise stay in IDLE.
- START (1 cycle):
  - add_en=EN_ASSERT.
  - Next state WAIT; counter cleared to 0.
- WAIT:
  - add_en deasserted; add_a/add_b held stable.
  - Counter increments each cycle; when counter==ADD_LAT-1 -> CAPT.
  - WAIT lasts exactly ADD_LAT cycles.
- CAPT:
  - Result slot is free when res_valid==0 or res_ready==1.
  - If free: res_sum<=add_out, res_valid<=1, -> REL.
  - If not free: stall in CAPT, add_en deasserted. The adder holds its result in its done state.
- REL (1 cycle):
  - add_en=EN_ASSERT, which returns the adder to idle.
  - FIFO non-empty -> START (pop); otherwise -> IDLE.
- Result port:
  - res_valid clears on res_valid&&res_ready unless CAPT reloads in the same cycle.
  - In that case the new value replaces the old one and res_valid stays 1.
  - res_sum is held while res_valid=1 and res_ready=0.
- Arithmetic: the sum is W bits, modulo 2^W, as produced by the adder; this block does no arithmetic on the data path.
- Latency: accept at edge k gives first START at cycle k+1 (empty FIFO, IDLE), and res_valid rises ADD_LAT+2 cycles later.
- busy = (state!=IDLE).

Optional Feature:
- Macro: ADD_SERIAL_FEEDER_CHK_EN.
- When defined:
  - Adds output port err (1 bit, reset 0).
  - At each CAPT load, compares add_out with (add_a+add_b) mod 2^W.
  - On mismatch, err is set and stays sticky until reset.
- When undefined: no err port and no comparator logic.

Test Plan:
- Reset: rst low -> in_ready=1, res_valid=0, add_en=1, busy=0, res_sum=0.
- Single op, behavioural adder model: push a=8'h35,b=8'h4A, res_ready=1 -> one add_en low pulse, then res_valid=1 with res_sum=8'h7F exactly ADD_LAT+2 cycles after START; REL add_en pulse follows.
- Wrap: a=8'hFF,b=8'h02 -> res_sum=8'h01.
- Back-to-back with res_ready=1: push 3 pairs (1+2, 10+20, 200+100):
  - in_ready drops after 2 are queued.
  - Sums 3, 30, 44 appear.
  - START pulses 11 cycles apart.
- Backpressure: res_ready=0 with two ops queued -> FSM stalls in CAPT for the second op, first res_sum held; res_ready=1 -> second sum loads the next cycle.
- Async reset asserted during WAIT -> all outputs return to reset values immediately; no res_valid after release. With CHK_EN, a model adder injecting 8'h00 for 1+1 -> err=1 and err stays set.

Source files
------------

// File: rtl/add_serial_feeder_if.sv
// Handshake and adder-side signal bundle for add_serial_feeder.
// The err signal exists only when ADD_SERIAL_FEEDER_CHK_EN is defined.
interface add_serial_feeder_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_en;
    logic [W-1:0] add_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         busy;
`ifdef ADD_SERIAL_FEEDER_CHK_EN
    logic         err;

    modport master (
        input  in_valid, in_a, in_b, add_out, res_ready,
        output in_ready, add_a, add_b, add_en, res_valid, res_sum, busy, err
    );
    modport slave (
        output in_valid, in_a, in_b, add_out, res_ready,
        input  in_ready, add_a, add_b, add_en, res_valid, res_sum, busy, err
    );
`else
    modport master (
        input  in_valid, in_a, in_b, add_out, res_ready,
        output in_ready, add_a, add_b, add_en, res_valid, res_sum, busy
    );
    modport slave (
        output in_valid, in_a, in_b, add_out, res_ready,
        input  in_ready, add_a, add_b, add_en, res_valid, res_sum, busy
    );
`endif
endinterface

// File: rtl/add_serial_feeder.sv
// Operand sequencer feeding an 8-bit bit-serial adder: operand FIFO, latency timer, result slot.
// Optional sum checker with sticky err output enabled by ADD_SERIAL_FEEDER_CHK_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no operation; wait for FIFO non-empty
// S_START | operands presented, add_en pulsed to launch the adder
// S_WAIT  | ADD_LAT cycles of serial computation, operands held
// S_CAPT  | load add_out into result slot once the slot is free
// S_REL   | add_en pulsed to return the adder to idle
module add_serial_feeder #(
    parameter int   W         = 8,
    parameter int   DEPTH     = 2,
    parameter int   ADD_LAT   = 8,
    parameter logic EN_ASSERT = 1'b0
) (
    input logic clk,
    input logic rst,
    add_serial_feeder_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_CAPT, S_REL} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   mem_a [DEPTH];
    logic [W-1:0]   mem_b [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic           in_ready_q;
    logic           push, pop, fifo_empty, capt_load;
    logic [LW-1:0]  wait_cnt;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic           res_valid_q;

    assign fifo_empty = (count == '0);
    assign push       = bus.in_valid && in_ready_q;
    assign count_nxt  = count + CW'(push) - CW'(pop);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capt_load = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = S_START;
                    pop       = 1'b1;
                end
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == LW'(ADD_LAT - 1)) state_nxt = S_CAPT;
            end
            S_CAPT: begin
                // slot is free if empty or being drained this cycle
                if (!res_valid_q || bus.res_ready) begin
                    capt_load = 1'b1;
                    state_nxt = S_REL;
                end
            end
            S_REL: begin
                if (!fifo_empty) begin
                    state_nxt = S_START;
                    pop       = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            wait_cnt    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            in_ready_q <= (count_nxt != CW'(DEPTH));
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                a_q    <= mem_a[rd_ptr];
                b_q    <= mem_b[rd_ptr];
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            else                 wait_cnt <= '0;
            if (capt_load) begin
                sum_q       <= bus.add_out;
                res_valid_q <= 1'b1;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef ADD_SERIAL_FEEDER_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (capt_load && (bus.add_out != W'(a_q + b_q))) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.add_a     = a_q;
    assign bus.add_b     = b_q;
    assign bus.add_en    = (state == S_START || state == S_REL) ? EN_ASSERT : ~EN_ASSERT;
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_add_serial_feeder.sv
// Self-checking bench for add_serial_feeder with a behavioural bit-serial adder model.
module tb_add_serial_feeder;
    localparam int W       = 8;
    localparam int ADD_LAT = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    add_serial_feeder_if #(.W(W)) bus ();

    add_serial_feeder #(
        .W(W), .DEPTH(2), .ADD_LAT(ADD_LAT), .EN_ASSERT(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // adder model: en low in idle launches, result final ADD_LAT edges later, en low in done releases
    int   m_st;
    int   m_cnt;
    logic inject = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st        <= 0;
            m_cnt       <= 0;
            bus.add_out <= '0;
        end else begin
            case (m_st)
                0: if (bus.add_en == 1'b0) begin
                    m_st        <= 1;
                    m_cnt       <= ADD_LAT;
                    bus.add_out <= '0;
                end
                1: if (m_cnt != 0) begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) begin
                        m_st <= 2;
                        if (inject && bus.add_a == 8'd1 && bus.add_b == 8'd1) bus.add_out <= '0;
                        else bus.add_out <= bus.add_a + bus.add_b;
                    end
                end
                default: if (bus.add_en == 1'b0) m_st <= 0;
            endcase
        end
    end

    int           starts[$];
    logic [W-1:0] results[$];
    int           en_low_cnt = 0;
    int           rise_cnt   = 0;
    int           last_rise  = 0;
    logic         en_at_rise = 1'b1;
    logic         rv_prev    = 1'b0;
    always @(negedge clk) begin
        if (bus.add_en == 1'b0 && m_st == 0) starts.push_back(cyc);
        if (bus.add_en == 1'b0) en_low_cnt <= en_low_cnt + 1;
        if (bus.res_valid && bus.res_ready) results.push_back(bus.res_sum);
        if (bus.res_valid && !rv_prev) begin
            rise_cnt   <= rise_cnt + 1;
            last_rise  <= cyc;
            en_at_rise <= bus.add_en;
        end
        rv_prev <= bus.res_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        while (!bus.in_ready && n < 60) begin
            tick();
            n++;
        end
        if (!bus.in_ready) timeout("push");
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_rise(output bit ok);
        int r0 = rise_cnt;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rise_cnt != r0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_rise");
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy || bus.res_valid) && n < 60) begin
            tick();
            n++;
        end
        if (bus.busy || bus.res_valid) timeout("wait_idle");
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit ok;
        int n0, e0, r0;
        vecs[0] = '{8'h35, 8'h4A, 8'h7F};
        vecs[1] = '{8'hFF, 8'h02, 8'h01};
        vecs[2] = '{8'h00, 8'h00, 8'h00};
        vecs[3] = '{8'h80, 8'h80, 8'h00};
        vecs[4] = '{8'h01, 8'hFE, 8'hFF};
        vecs[5] = '{8'h55, 8'h2B, 8'h80};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_add_en",    bus.add_en,    1);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_res_sum",   bus.res_sum,   0);
`ifdef ADD_SERIAL_FEEDER_CHK_EN
        chk("rst_err", bus.err, 0);
`endif
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            n0 = starts.size();
            e0 = en_low_cnt;
            push(vecs[i].a, vecs[i].b);
            wait_rise(ok);
            if (ok) begin
                chk($sformatf("vec%0d_sum", i), results[$], vecs[i].sum);
                chk($sformatf("vec%0d_lat", i), last_rise - starts[$], ADD_LAT + 2);
                chk($sformatf("vec%0d_rel_en", i), en_at_rise, 0);
            end
            wait_idle();
            chk($sformatf("vec%0d_starts", i), starts.size() - n0, 1);
            chk($sformatf("vec%0d_en_pulses", i), en_low_cnt - e0, 2);
        end

        // back-to-back: third push fills the FIFO
        n0 = starts.size();
        r0 = results.size();
        push(8'd1, 8'd2);
        push(8'd10, 8'd20);
        push(8'd200, 8'd100);
        chk("b2b_in_ready_full", bus.in_ready, 0);
        for (int i = 0; i < 100 && results.size() < r0 + 3; i++) tick();
        if (results.size() < r0 + 3) timeout("b2b_results");
        else begin
            chk("b2b_sum0", results[r0],     8'd3);
            chk("b2b_sum1", results[r0 + 1], 8'd30);
            chk("b2b_sum2", results[r0 + 2], 8'd44);
            chk("b2b_gap0", starts[n0 + 1] - starts[n0],     ADD_LAT + 3);
            chk("b2b_gap1", starts[n0 + 2] - starts[n0 + 1], ADD_LAT + 3);
        end
        wait_idle();

        // backpressure: second op stalls in CAPT while first sum is held
        bus.res_ready = 1'b0;
        r0 = results.size();
        push(8'd10, 8'd5);
        push(8'd7, 8'd9);
        repeat (40) tick();
        chk("bp_valid_held", bus.res_valid, 1);
        chk("bp_sum_held",   bus.res_sum,   8'd15);
        chk("bp_busy_stall", bus.busy,      1);
        chk("bp_en_deassert", bus.add_en,   1);
        bus.res_ready = 1'b1;
        tick();
        chk("bp_reload_valid", bus.res_valid, 1);
        chk("bp_reload_sum",   bus.res_sum,   8'd16);
        tick();
        chk("bp_scoreboard_n", results.size() - r0, 2);
        if (results.size() == r0 + 2) begin
            chk("bp_first_out",  results[r0],     8'd15);
            chk("bp_second_out", results[r0 + 1], 8'd16);
        end
        wait_idle();

        // async reset in the middle of WAIT
        push(8'h11, 8'h22);
        for (int i = 0; i < 20 && m_st != 1; i++) tick();
        repeat (3) tick();
        chk("mid_busy_before", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready",  bus.in_ready,  1);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_add_en",    bus.add_en,    1);
        chk("mid_rst_busy",      bus.busy,      0);
        chk("mid_rst_res_sum",   bus.res_sum,   0);
        tick();
        tick();
        rst = 1'b1;
        r0 = rise_cnt;
        repeat (20) tick();
        chk("post_rst_no_result", rise_cnt - r0, 0);
        chk("post_rst_idle",      bus.busy,      0);

`ifdef ADD_SERIAL_FEEDER_CHK_EN
        chk("err_clear_before", bus.err, 0);
        inject = 1'b1;
        push(8'd1, 8'd1);
        wait_rise(ok);
        if (ok) chk("err_bad_sum", results[$], 8'd0);
        tick();
        chk("err_set", bus.err, 1);
        inject = 1'b0;
        wait_idle();
        push(8'd2, 8'd3);
        wait_rise(ok);
        if (ok) chk("err_good_sum", results[$], 8'd5);
        tick();
        chk("err_sticky", bus.err, 1);
        wait_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
